// File: rtl/noc_pkg.sv
// Shared types and constants for the NOC-to-device link receive path.
package noc_pkg;

  localparam int NOC_NOP        = 0;
  localparam int NOC_DEF_LINK_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    DISCARD = 2'd2
  } rx_state_t;

  // Default-width beat; the top specialises the data field to its LINK_W.
  typedef struct packed {
    logic                      last;
    logic [NOC_DEF_LINK_W-1:0] data;
  } noc_beat_t;

  function automatic logic is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/noc_pkt_fifo.sv
// Store-and-forward beat FIFO with a speculative write pointer that is either
// committed at end of packet or rewound to discard a partial packet.
module noc_pkt_fifo
  import noc_pkg::*;
#(
  parameter type beat_t = noc_beat_t,
  parameter int  DEPTH  = 16
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  i_wr_en,
  input  beat_t i_wr_beat,
  input  logic  i_commit,
  input  logic  i_rewind,
  input  logic  i_pop,
  output logic  o_spec_full,
  output logic  o_valid,
  output beat_t o_beat
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  beat_t         r_mem [DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr_spec;
  logic [PW-1:0] r_wr_commit;
  logic [PW-1:0] w_used;
  logic          w_wr;
  logic          w_pop;

  // Occupancy counts speculative beats, so a packet in flight reserves space.
  assign w_used      = r_wr_spec - r_rd;
  assign o_spec_full = (w_used == PW'(DEPTH));
  assign o_valid     = (r_rd != r_wr_commit);
  assign w_wr        = i_wr_en & ~o_spec_full;
  assign w_pop       = i_pop & o_valid;
  assign o_beat      = r_mem[r_rd[AW-1:0]];

  // Read, speculative-write and committed-write pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd        <= {PW{1'b0}};
      r_wr_spec   <= {PW{1'b0}};
      r_wr_commit <= {PW{1'b0}};
    end else begin
      if (w_pop) begin
        r_rd <= r_rd + PW'(1);
      end
      if (i_rewind) begin
        r_wr_spec <= r_wr_commit;
      end else if (w_wr) begin
        r_wr_spec <= r_wr_spec + PW'(1);
      end
      if (i_commit) begin
        r_wr_commit <= r_wr_spec + PW'(1);
      end
    end
  end

  // Beat storage; contents are only meaningful between rd and wr_spec.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_spec[AW-1:0]] <= i_wr_beat;
    end
  end

endmodule

// File: rtl/noc_link_rx_buffer.sv
// Receive endpoint of the NOC-to-device link: frames ctl/data beats into
// packets, buffers them whole, and streams committed packets to the device.
module noc_link_rx_buffer
  import noc_pkg::*;
#(
  parameter int LINK_W  = 8,
  parameter int DEPTH   = 16,
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              noc_to_dev_ctl,
  input  logic [LINK_W-1:0] noc_to_dev_data,
  output logic              pkt_valid,
  output logic [LINK_W-1:0] pkt_data,
  output logic              pkt_last,
  input  logic              pkt_ready,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  if (!is_pow2(DEPTH) || (DEPTH < 2) || (DEPTH < MAX_LEN) || (MAX_LEN < 1) ||
      ((MAX_LEN >> LINK_W) != 0) || (LINK_W < 4)) begin : g_param_check
    $error("noc_link_rx_buffer: illegal DEPTH/MAX_LEN/LINK_W combination");
  end

  typedef struct packed {
    logic              last;
    logic [LINK_W-1:0] data;
  } rx_beat_t;

  rx_state_t          r_state;
  rx_state_t          w_state_nxt;
  rx_state_t          w_hdr_state;
  logic [LINK_W-1:0]  r_rem;
  logic [LINK_W-1:0]  w_rem_nxt;
  logic [CNT_W-1:0]   r_drop_cnt;
  logic [CNT_W-1:0]   r_err_cnt;
  logic [CNT_W:0]     w_err_sum;
  logic [1:0]         w_err_add;
  logic               w_hdr_err;
  logic               w_drop_inc;
  logic               w_wr_en;
  logic               w_commit;
  logic               w_rewind;
  logic               w_spec_full;
  logic               w_fifo_valid;
  rx_beat_t           w_wr_beat;
  rx_beat_t           w_head;

  noc_pkt_fifo #(
    .beat_t (rx_beat_t),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_wr_en     (w_wr_en),
    .i_wr_beat   (w_wr_beat),
    .i_commit    (w_commit),
    .i_rewind    (w_rewind),
    .i_pop       (pkt_ready),
    .o_spec_full (w_spec_full),
    .o_valid     (w_fifo_valid),
    .o_beat      (w_head)
  );

  assign pkt_valid = w_fifo_valid;
  assign pkt_data  = w_head.data;
  assign pkt_last  = w_head.last;
  assign drop_cnt  = r_drop_cnt;
  assign err_cnt   = r_err_cnt;

  assign w_wr_beat.last = (r_rem == LINK_W'(1));
  assign w_wr_beat.data = noc_to_dev_data;

  // Decode of a control beat, shared by every state that can see a header.
  always_comb begin
    w_hdr_state = IDLE;
    w_hdr_err   = 1'b0;
    if (noc_to_dev_data == LINK_W'(NOC_NOP)) begin
      w_hdr_state = IDLE;
      w_hdr_err   = 1'b0;
    end else if (noc_to_dev_data > LINK_W'(MAX_LEN)) begin
      w_hdr_state = DISCARD;
      w_hdr_err   = 1'b1;
    end else begin
      w_hdr_state = PAYLOAD;
      w_hdr_err   = 1'b0;
    end
  end

  // Framing FSM next-state and FIFO control.
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_wr_en     = 1'b0;
    w_commit    = 1'b0;
    w_rewind    = 1'b0;
    w_drop_inc  = 1'b0;
    w_err_add   = 2'd0;
    case (r_state)
      IDLE: begin
        if (noc_to_dev_ctl) begin
          w_state_nxt = w_hdr_state;
          w_rem_nxt   = noc_to_dev_data;
          w_err_add   = {1'b0, w_hdr_err};
        end else begin
          w_err_add = 2'd1;
        end
      end
      PAYLOAD: begin
        if (noc_to_dev_ctl) begin
          // Truncated packet: discard it, then treat this beat as fresh framing.
          w_rewind    = 1'b1;
          w_state_nxt = w_hdr_state;
          w_rem_nxt   = noc_to_dev_data;
          w_err_add   = 2'd1 + {1'b0, w_hdr_err};
        end else if (w_spec_full) begin
          w_drop_inc  = 1'b1;
          w_rewind    = 1'b1;
          w_state_nxt = DISCARD;
        end else begin
          w_wr_en   = 1'b1;
          w_rem_nxt = r_rem - LINK_W'(1);
          if (r_rem == LINK_W'(1)) begin
            w_commit    = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = PAYLOAD;
          end
        end
      end
      DISCARD: begin
        if (noc_to_dev_ctl) begin
          w_state_nxt = w_hdr_state;
          w_rem_nxt   = noc_to_dev_data;
          w_err_add   = {1'b0, w_hdr_err};
        end else begin
          w_state_nxt = DISCARD;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // FSM state and remaining-beat counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_rem   <= {LINK_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  assign w_err_sum = {1'b0, r_err_cnt} + (CNT_W + 1)'(w_err_add);

  // Saturating status counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_cnt <= {CNT_W{1'b0}};
      r_err_cnt  <= {CNT_W{1'b0}};
    end else begin
      if (w_drop_inc && (r_drop_cnt != {CNT_W{1'b1}})) begin
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
      r_err_cnt <= w_err_sum[CNT_W] ? {CNT_W{1'b1}} : w_err_sum[CNT_W-1:0];
    end
  end

endmodule
